alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
Execute-stage controller that sits directly upstream of the 8-bit combinational ALU and consumes its result. It accepts one 16-bit instruction per handshake and reads operands from an internal 8x8 register file. It drives the ALU operand and control inputs, registers the ALU result and writes it back. Between instructions it services a single interrupt request.

Parameters:
NUM_REGS, 8, register-file depth; fixes the register index width at 3.
DATA_W, 8, datapath width; must match the ALU.
MAX_OP, 10, highest legal opcode (0-10 map 1:1 onto ALU control codes).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
instr_valid  in  1  instruction available
instr  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored
instr_ready  out  1  stage can accept an instruction
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_ctrl  out  4  ALU control code
alu_result  in  8  combinational ALU output
wb_valid  out  1  one-cycle pulse on register write-back
wb_rd  out  3  write-back destination
wb_data  out  8  write-back value
zero_flag  out  1  last written result == 0
illegal_op  out  1  one-cycle pulse on rejected opcode
irq  in  1  level interrupt request
irq_ack  out  1  one-cycle acknowledge
dbg_addr  in  3  debug register read address
dbg_data  out  8  combinational register read; r0 reads 0

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset. Reset clears all registers, flags and outputs to 0 and the FSM to IDLE. instr_ready is 1 in the cycle after reset deasserts unless irq is high.
- States: IDLE, EXEC, WB, TRAP, IRQ.
- IDLE:
  - instr_ready = !irq.
  - If irq is high: go to IRQ. No instruction is accepted that cycle, even if instr_valid is high; irq wins.
  - Else if instr_valid: latch instr. If opcode > MAX_OP go to TRAP, otherwise go to EXEC.
- EXEC:
  - alu_a = reg[rs1], alu_b = reg[rs2], alu_ctrl = latched opcode.
  - Register alu_result into wb_data and go to WB.
- WB:
  - wb_valid = 1, wb_rd = latched rd.
  - Write reg[rd] = wb_data unless rd == 0. r0 is hardwired to 0 and writes to it are discarded, but wb_valid still pulses.
  - zero_flag = (wb_data == 0), updated on every WB including rd == 0.
  - Go to IDLE.
- TRAP: illegal_op = 1 for one cycle. No register write, zero_flag unchanged. Go to IDLE.
- IRQ: irq_ack = 1 for one cycle, then go to IDLE. If irq is still high in IDLE, a new IRQ visit follows; holding irq starves instructions, and that is intended.
- ALU outputs outside EXEC: alu_a, alu_b and alu_ctrl are 0.
- Latency: accept in cycle N, EXEC in N+1, WB pulse in N+2, instr_ready high again in N+3. Peak throughput is one instruction per 3 cycles.
- Hazards: none, because instructions are strictly serialized. An instruction reading a register written by the previous one sees the new value.
- Arithmetic: all values are 8-bit and wrap. This block imposes no carry or overflow. A modulus-by-zero result of 0xFF is written back as-is.
- Reset mid-operation: the in-flight instruction is abandoned with no write, and no wb_valid, illegal_op or irq_ack pulse occurs.
- instr is sampled only on the accepting cycle. Changes to instr while not ready are ignored.

Decomposition:
- Shared package: opcode constants (OP_ADD=0 … OP_NOT=10), MAX_OP, the state enum, and instruction field positions. The same opcode constants are used by the ALU.
- One natural sub-module, alu_regfile: 8x8, one write port, three combinational read ports (rs1, rs2, dbg), r0 hardwired to 0.

Test Plan:
1. Reset, write r1=5 and r2=3 by ADD from r0 (yields 0), then ADD r3=r1+r2 → wb_valid at accept+2, wb_rd=3, wb_data=8, zero_flag=0, dbg_addr=3 returns 8. Register seeding goes through a bench-only backdoor or a preceding instruction sequence.
2. SUB r4=r2-r1 with r2=3, r1=5 → wb_data=0xFE. Then SUB r5=r1-r1 → wb_data=0, zero_flag=1.
3. Opcode 4'hC → illegal_op pulses exactly one cycle at accept+1, no wb_valid, all registers and zero_flag unchanged, instr_ready high at accept+2.
4. irq and instr_valid both high in IDLE → instr_ready=0, irq_ack pulse next cycle. The instruction is accepted after irq drops and executes correctly.
5. MOD with rs2=r0 → wb_data=0xFF. Any write with rd=0 → wb_valid=1, dbg read of r0 stays 0.
6. Assert reset during EXEC → no wb_valid, all registers read 0, FSM in IDLE with instr_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the execute-stage controller and its ALU.
// Opcode values double as ALU control codes.
package alu_exec_ctrl_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int OP_W     = 4;
    localparam int INSTR_W  = 16;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL = 4'd8;
    localparam logic [OP_W-1:0] OP_MOD = 4'd9;
    localparam logic [OP_W-1:0] OP_NOT = 4'd10;
    localparam logic [OP_W-1:0] MAX_OP = OP_NOT;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB,
        ST_TRAP,
        ST_IRQ
    } state_t;

    function automatic logic [OP_W-1:0] f_op(input logic [INSTR_W-1:0] i);
        return i[OPC_LSB +: OP_W];
    endfunction

    function automatic logic [REG_W-1:0] f_reg(input logic [INSTR_W-1:0] i,
                                               input int lsb);
        return i[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x8 register file: one write port, three combinational read ports.
// r0 always reads zero and ignores writes.
module alu_regfile
    import alu_exec_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [REG_W-1:0]  rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage: cleared on reset, r0 never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: fetches operands, drives the external ALU,
// writes the result back and services a single interrupt between ops.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_ctrl,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               wb_valid,
    output logic [REG_W-1:0]   wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               zero_flag,
    output logic               illegal_op,
    input  logic               irq,
    output logic               irq_ack,
    input  logic [REG_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t            state;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rf_we;
    logic [OP_W-1:0]   op_in;
    logic              unused_instr;

    assign op_in        = f_op(instr);
    assign unused_instr = ^instr[2:0];

    // Ready only while idle; a pending interrupt blocks acceptance.
    assign instr_ready = (state == ST_IDLE) && !irq;

    // Commit the held result during the write-back cycle.
    assign rf_we = (state == ST_WB);

    alu_regfile u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (wb_rd),
        .wdata    (wb_data),
        .rs1_addr (f_reg(instr, RS1_LSB)),
        .rs1_data (rs1_data),
        .rs2_addr (f_reg(instr, RS2_LSB)),
        .rs2_data (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Sequencer with registered ALU drive, pulses and write-back state.
    // Operands are read in the accepting cycle, so they are already
    // stable on the ALU inputs throughout EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            zero_flag  <= 1'b0;
            illegal_op <= 1'b0;
            irq_ack    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            illegal_op <= 1'b0;
            irq_ack    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (irq) begin
                        state   <= ST_IRQ;
                        irq_ack <= 1'b1;
                    end else if (instr_valid) begin
                        rd_q <= f_reg(instr, RD_LSB);
                        if (op_in > MAX_OP) begin
                            state      <= ST_TRAP;
                            illegal_op <= 1'b1;
                        end else begin
                            state    <= ST_EXEC;
                            alu_a    <= rs1_data;
                            alu_b    <= rs2_data;
                            alu_ctrl <= op_in;
                        end
                    end
                end
                ST_EXEC: begin
                    state     <= ST_WB;
                    wb_data   <= alu_result;
                    zero_flag <= (alu_result == '0);
                    wb_valid  <= 1'b1;
                    wb_rd     <= rd_q;
                end
                ST_WB:   state <= ST_IDLE;
                ST_TRAP: state <= ST_IDLE;
                ST_IRQ:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
